// File: rtl/forward_scoreboard_pkg.sv
// Shared types for the forwarding scoreboard: stage-select encoding seen by the rs* operand muxes.
package forward_scoreboard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REGFILE = 2'd0;
  localparam fwd_sel_t FWD_EXMEM   = 2'd1;
  localparam fwd_sel_t FWD_MEMWB   = 2'd2;
  localparam fwd_sel_t FWD_WBLATE  = 2'd3;

endpackage

// File: rtl/forward_scoreboard_entry.sv
// One scoreboard entry: busy/age/lat flops for a single architectural register.
// Freeze holds all state; issue wins over writeback; flush squashes entries younger than FLUSH_AGE.
module forward_scoreboard_entry
  import forward_scoreboard_pkg::*;
#(
  parameter int AGE_W     = 3,
  parameter int FLUSH_AGE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_freeze,
  input  logic             i_flush,
  input  logic             i_issue,
  input  logic             i_wb,
  input  logic [AGE_W-1:0] i_lat,
  output logic             o_busy,
  output logic [AGE_W-1:0] o_age,
  output logic [AGE_W-1:0] o_lat
);

  localparam logic [AGE_W:0] FLUSH_AGE_C = (AGE_W+1)'(FLUSH_AGE);

  logic             r_busy;
  logic [AGE_W-1:0] r_age;
  logic [AGE_W-1:0] r_lat;
  logic             w_young;
  logic [AGE_W-1:0] w_age_inc;

  // Flush looks at the age before this cycle's increment.
  assign w_young   = r_busy && ({1'b0, r_age} < FLUSH_AGE_C);
  assign w_age_inc = (r_age == '1) ? r_age : r_age + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_age  <= '0;
      r_lat  <= '0;
    end else if (!i_freeze) begin
      if (i_issue) begin
        r_busy <= 1'b1;
        r_age  <= '0;
        r_lat  <= i_lat;
      end else begin
        if (r_busy) r_age <= w_age_inc;
        if (i_wb || (i_flush && w_young)) r_busy <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_age  = r_age;
  assign o_lat  = r_lat;

endmodule

// File: rtl/forward_scoreboard.sv
// Per-register in-flight write scoreboard with forwarding-stage select and load-use stall.
// Selects and stall are combinational (zero latency); freeze holds state and masks the stall.
module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int NUM_FWD   = 3,
  parameter int REG_IDX_W = 5,
  parameter int AGE_W     = 3,
  parameter int FLUSH_AGE = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_freeze,
  input  logic                         i_flush,
  input  logic                         i_issue_valid,
  input  logic [REG_IDX_W-1:0]         i_issue_rd,
  input  logic                         i_issue_wen,
  input  logic [AGE_W-1:0]             i_issue_lat,
  input  logic [NUM_SRC*REG_IDX_W-1:0] i_src_idx,
  input  logic [NUM_SRC-1:0]           i_src_used,
  input  logic [NUM_FWD*REG_IDX_W-1:0] i_stage_rd,
  input  logic [NUM_FWD-1:0]           i_stage_fwd_ok,
  input  logic                         i_wb_valid,
  input  logic [REG_IDX_W-1:0]         i_wb_rd,
  output logic [NUM_SRC*2-1:0]         o_fwd_sel,
  output logic                         o_fwd_stall,
  output logic [2**REG_IDX_W-1:0]      o_busy_vec
);

  localparam int NREG = 2**REG_IDX_W;

  logic [NREG-1:0]  w_busy;
  logic [AGE_W-1:0] w_age [NREG];
  logic [AGE_W-1:0] w_lat [NREG];
  logic             w_issue_en;
  logic             w_wb_en;
  logic             w_stall;

  // x0 is never tracked; a stalled or flushed cycle does not issue.
  assign w_issue_en = i_issue_valid && i_issue_wen && !i_freeze && !i_flush && !w_stall
                      && (i_issue_rd != '0);
  assign w_wb_en    = i_wb_valid && !i_freeze && (i_wb_rd != '0);

  for (genvar r = 0; r < NREG; r++) begin : g_entry
    forward_scoreboard_entry #(
      .AGE_W     (AGE_W),
      .FLUSH_AGE (FLUSH_AGE)
    ) u_entry (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_freeze (i_freeze),
      .i_flush  (i_flush),
      .i_issue  (w_issue_en && (i_issue_rd == REG_IDX_W'(r))),
      .i_wb     (w_wb_en && (i_wb_rd == REG_IDX_W'(r))),
      .i_lat    (i_issue_lat),
      .o_busy   (w_busy[r]),
      .o_age    (w_age[r]),
      .o_lat    (w_lat[r])
    );
  end

  // Age reads 0 in the first cycle after issue, so the result is ready once age+1 reaches lat.
  always_comb begin
    logic [REG_IDX_W-1:0] w_src;
    fwd_sel_t             w_sel;
    logic                 w_ready;
    o_fwd_sel = '0;
    w_stall   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_src   = i_src_idx[i*REG_IDX_W +: REG_IDX_W];
      w_sel   = FWD_REGFILE;
      w_ready = ({1'b0, w_age[w_src]} + 1'b1) >= {1'b0, w_lat[w_src]};
      if (i_src_used[i] && (w_src != '0)) begin
        for (int k = NUM_FWD-1; k >= 0; k--) begin
          if (i_stage_fwd_ok[k] && (i_stage_rd[k*REG_IDX_W +: REG_IDX_W] == w_src))
            w_sel = fwd_sel_t'(k+1);
        end
        if (w_busy[w_src] && (!w_ready || (w_sel == FWD_REGFILE)))
          w_stall = 1'b1;
      end
      o_fwd_sel[i*2 +: 2] = i_rst ? FWD_REGFILE : w_sel;
    end
  end

  assign o_fwd_stall = w_stall && !i_freeze && !i_rst;
  assign o_busy_vec  = w_busy;

endmodule
